// File: rtl/tlb_search_arb.sv
// Arbitrates the shared TLB search port between inst fetch, data access and TLBSRCH.
// The TLB result for the granted requester is registered into a one-cycle response pulse.
module tlb_search_arb #(
  parameter  int unsigned TLBNUM     = 16,
  parameter  int unsigned STARVE_MAX = 2,
  localparam int unsigned IDXW       = $clog2(TLBNUM),
  localparam int unsigned SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_req,
  input  logic            d_req,
  input  logic            c_req,
  input  logic [19:0]     i_vpn,
  input  logic [19:0]     d_vpn,
  input  logic [19:0]     c_vpn,
  input  logic [9:0]      i_asid,
  input  logic [9:0]      d_asid,
  input  logic [9:0]      c_asid,
  output logic            i_ready,
  output logic            d_ready,
  output logic            c_ready,
  input  logic            flush,
  input  logic            tlb_busy,
  output logic [18:0]     s_vppn,
  output logic            s_va_bit12,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  input  logic [19:0]     s_ppn,
  input  logic [5:0]      s_ps,
  input  logic [1:0]      s_plv,
  input  logic [1:0]      s_mat,
  input  logic            s_d,
  input  logic            s_v,
  output logic [2:0]      r_valid,
  output logic            r_found,
  output logic [IDXW-1:0] r_index,
  output logic [19:0]     r_ppn,
  output logic [5:0]      r_ps,
  output logic [1:0]      r_plv,
  output logic [1:0]      r_mat,
  output logic            r_d,
  output logic            r_v
);

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } rsp_t;

  logic [SW-1:0] starve_cnt_d, starve_cnt_q;
  logic [2:0]    r_valid_d, r_valid_q;
  rsp_t          rsp_d, rsp_q;

  logic cand_i, cand_d, cand_c, grant_ok, promote;
  logic [19:0] vpn_sel;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cand_c   = c_req;
    cand_d   = d_req & ~flush;
    cand_i   = i_req & ~flush;
    // Readies stay low during reset as well as while the TLB is being written.
    grant_ok = resetn & ~tlb_busy;
    promote  = cand_i & (starve_cnt_q == SW'(STARVE_MAX));

    c_ready  = grant_ok & cand_c;
    d_ready  = grant_ok & ~cand_c & cand_d & ~promote;
    i_ready  = grant_ok & ~cand_c & cand_i & (promote | ~cand_d);

    vpn_sel  = i_vpn;
    s_asid   = i_asid;
    if (c_ready) begin
      vpn_sel = c_vpn;
      s_asid  = c_asid;
    end else if (d_ready) begin
      vpn_sel = d_vpn;
      s_asid  = d_asid;
    end
    s_vppn     = vpn_sel[19:1];
    s_va_bit12 = vpn_sel[0];

    starve_cnt_d = starve_cnt_q;
    if (~i_req | i_ready) begin
      starve_cnt_d = '0;
    end else if (~flush & ~tlb_busy && starve_cnt_q != SW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    r_valid_d = {c_ready, d_ready, i_ready};
    rsp_d     = rsp_q;
    if (|r_valid_d) begin
      rsp_d = '{found: s_found, index: s_index, ppn: s_ppn, ps: s_ps,
                plv: s_plv, mat: s_mat, d: s_d, v: s_v};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
      r_valid_q    <= '0;
      rsp_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      r_valid_q    <= r_valid_d;
      rsp_q        <= rsp_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_found = rsp_q.found;
  assign r_index = rsp_q.index;
  assign r_ppn   = rsp_q.ppn;
  assign r_ps    = rsp_q.ps;
  assign r_plv   = rsp_q.plv;
  assign r_mat   = rsp_q.mat;
  assign r_d     = rsp_q.d;
  assign r_v     = rsp_q.v;

endmodule

// File: tb/tb_tlb_search_arb.sv
// Table-driven bench for tlb_search_arb: per-cycle grant vectors, a response scoreboard
// and hand-written reset sequences.
module tb_tlb_search_arb;

  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            i_req, d_req, c_req;
  logic [19:0]     i_vpn, d_vpn, c_vpn;
  logic [9:0]      i_asid, d_asid, c_asid;
  logic            i_ready, d_ready, c_ready;
  logic            flush, tlb_busy;
  logic [18:0]     s_vppn;
  logic            s_va_bit12;
  logic [9:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [19:0]     s_ppn;
  logic [5:0]      s_ps;
  logic [1:0]      s_plv, s_mat;
  logic            s_d, s_v;
  logic [2:0]      r_valid;
  logic            r_found;
  logic [IDXW-1:0] r_index;
  logic [19:0]     r_ppn;
  logic [5:0]      r_ps;
  logic [1:0]      r_plv, r_mat;
  logic            r_d, r_v;

  tlb_search_arb #(.TLBNUM(16), .STARVE_MAX(2)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .d_req(d_req), .c_req(c_req),
    .i_vpn(i_vpn), .d_vpn(d_vpn), .c_vpn(c_vpn),
    .i_asid(i_asid), .d_asid(d_asid), .c_asid(c_asid),
    .i_ready(i_ready), .d_ready(d_ready), .c_ready(c_ready),
    .flush(flush), .tlb_busy(tlb_busy),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .r_valid(r_valid), .r_found(r_found), .r_index(r_index), .r_ppn(r_ppn),
    .r_ps(r_ps), .r_plv(r_plv), .r_mat(r_mat), .r_d(r_d), .r_v(r_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       i, d, c, fl, busy;
    logic [2:0] exp_rdy;   // {c, d, i}
    logic [1:0] exp_st;    // starvation count seen during this cycle
  } vec_t;

  typedef struct packed {
    logic [2:0]      valid;
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  rsp_t last_rsp;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic i, d, c, fl, busy, input logic [2:0] r, input logic [1:0] st);
    vec_t v;
    v.i = i; v.d = d; v.c = c; v.fl = fl; v.busy = busy; v.exp_rdy = r; v.exp_st = st;
    return v;
  endfunction

  // TLB lookup result the bench presents in cycle k; row 0 is the single data search case.
  task automatic drive_tlb(input int k);
    logic [19:0] p;
    p = (k == 0) ? 20'hABCDE : (20'h3_0000 ^ 20'(k * 20'h0_4F1B));
    s_ppn   = p;
    s_ps    = (k == 0) ? 6'd12 : 6'(k);
    s_found = ~p[0];
    s_index = p[IDXW-1:0];
    s_plv   = p[5:4];
    s_mat   = p[7:6];
    s_d     = p[8];
    s_v     = p[9];
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " r_valid"}, 32'(r_valid), 32'(e.valid));
    check({tag, " r_ppn"},   32'(r_ppn),   32'(e.ppn));
    check({tag, " r_misc"},  32'({r_found, r_index, r_ps, r_plv, r_mat, r_d, r_v}),
                             32'({e.found, e.index, e.ps, e.plv, e.mat, e.d, e.v}));
  endtask

  // Predicts the response registered for the grant expected this cycle.
  task automatic push_expected(input logic [2:0] rdy);
    rsp_t e;
    e = last_rsp;
    e.valid = rdy;
    if (rdy != 3'b000) begin
      e.found = s_found; e.index = s_index; e.ppn = s_ppn; e.ps = s_ps;
      e.plv = s_plv; e.mat = s_mat; e.d = s_d; e.v = s_v;
      last_rsp = e;
    end
    sb.push_back(e);
  endtask

  initial begin
    logic [19:0] exp_vpn;
    logic [9:0]  exp_asid;

    i_vpn = 20'h0_0AAB; i_asid = 10'h011;
    d_vpn = 20'h1_2345; d_asid = 10'h003;
    c_vpn = 20'hF_0F0E; c_asid = 10'h2C5;
    flush = 1'b0; tlb_busy = 1'b0;
    drive_tlb(1);
    last_rsp = '0;

    // Reset state with every requester asserting.
    resetn = 1'b0;
    i_req = 1'b1; d_req = 1'b1; c_req = 1'b1;
    #3;
    check("reset readies", 32'({c_ready, d_ready, i_ready}), 32'd0);
    check("reset r_valid", 32'(r_valid), 32'd0);
    check("reset r_ppn",   32'(r_ppn),   32'd0);
    check("reset r_misc",  32'({r_found, r_index, r_ps, r_plv, r_mat, r_d, r_v}), 32'd0);
    i_req = 1'b0; d_req = 1'b0; c_req = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    //            i     d     c     fl    busy  {c,d,i}  st
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd0)); // single data search
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 2'd0)); // priority c
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1)); // then d
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'd2)); // then i
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd0)); // starvation d,d,i,d,d,i
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 2'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 2'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 2'd0)); // flush: only c
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd0)); // d after flush
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'd1)); // flush, earlier rsp still shown
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd1)); // busy holds count
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 2'd1)); // busy with c, 2 cycles
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 2'd0)); // c granted as busy drops
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0)); // idle
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'd1)); // flush holds count
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 2'd2)); // c beats promoted i; saturates
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 2'd2));

    for (int k = 0; k < vecs.size(); k++) begin
      string tag;
      tag = $sformatf("v%0d", k);
      i_req = vecs[k].i; d_req = vecs[k].d; c_req = vecs[k].c;
      flush = vecs[k].fl; tlb_busy = vecs[k].busy;
      drive_tlb(k);
      #4;
      check({tag, " ready"}, 32'({c_ready, d_ready, i_ready}), 32'(vecs[k].exp_rdy));
      check({tag, " starve"}, 32'(dut.starve_cnt_q), 32'(vecs[k].exp_st));
      exp_vpn  = vecs[k].exp_rdy[2] ? c_vpn  : vecs[k].exp_rdy[1] ? d_vpn  : i_vpn;
      exp_asid = vecs[k].exp_rdy[2] ? c_asid : vecs[k].exp_rdy[1] ? d_asid : i_asid;
      check({tag, " s_vppn"}, 32'({s_vppn, s_va_bit12}), 32'(exp_vpn));
      check({tag, " s_asid"}, 32'(s_asid), 32'(exp_asid));
      push_expected(vecs[k].exp_rdy);
      @(posedge clk); #1;
      check_rsp(tag);
    end
    check("data vppn const", 32'({dut.d_vpn[19:1], dut.d_vpn[0]}), 32'({19'h091A2, 1'b1}));

    // Mid-cycle reset with a data request and a response pending.
    i_req = 1'b1; d_req = 1'b1; c_req = 1'b0; flush = 1'b0; tlb_busy = 1'b0;
    drive_tlb(40);
    #4;
    check("rst_seq d_ready", 32'(d_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_seq r_valid pre", 32'(r_valid), 32'b010);
    check("rst_seq starve pre", 32'(dut.starve_cnt_q), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_seq r_valid", 32'(r_valid), 32'd0);
    check("rst_seq r_ppn",   32'(r_ppn),   32'd0);
    check("rst_seq ready",   32'({c_ready, d_ready, i_ready}), 32'd0);
    check("rst_seq starve",  32'(dut.starve_cnt_q), 32'd0);
    sb.delete();
    last_rsp = '0;
    @(negedge clk); resetn = 1'b1;
    drive_tlb(41);
    #1;
    check("rst_seq d_ready post", 32'({c_ready, d_ready, i_ready}), 32'b010);
    push_expected(3'b010);
    @(posedge clk); #1;
    check_rsp("rst_seq post");

    i_req = 1'b0; d_req = 1'b0;
    #4;
    push_expected(3'b000);
    @(posedge clk); #1;
    check_rsp("rst_seq idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
